// File: rtl/bsg_chip_host_link_selector_pkg.sv
// Shared constants and types for the runtime-selectable host link attach point.
package bsg_chip_host_link_selector_pkg;

    localparam int unsigned host_link_num_channels_gp  = 4;
    localparam int unsigned host_link_max_out_gp       = 32;
    localparam int unsigned host_link_drain_timeout_gp = 1024;

    // Manycore fwd/rev packet widths
    localparam int unsigned host_link_fwd_width_gp = 128;
    localparam int unsigned host_link_rev_width_gp = 64;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } host_link_state_e;

endpackage

// File: rtl/bsg_chip_host_link_credit_ctr.sv
// Saturating up/down outstanding-request counter with clear and underflow detect.
module bsg_chip_host_link_credit_ctr #(
    parameter int unsigned max_p = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         inc_i,
    input  logic                         dec_i,
    input  logic                         clear_i,
    output logic [$clog2(max_p+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         underflow_c_o
);

    localparam int unsigned cnt_width_lp = $clog2(max_p + 1);

    logic [cnt_width_lp-1:0] count_q, count_d;

    assign count_o = count_q;
    assign full_o  = (count_q == cnt_width_lp'(max_p));

    // A decrement with nothing outstanding is reported, never wrapped.
    assign underflow_c_o = dec_i & ~inc_i & (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            if (!full_o) begin
                count_d = count_q + cnt_width_lp'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) begin
                count_d = count_q - cnt_width_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry valid/ready buffer; registered output, full throughput, synchronous clear.
module bsg_two_fifo #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [1:0][width_p-1:0] mem_q, mem_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    enq, deq;

    assign ready_o = (cnt_q != 2'd2);
    assign v_o     = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + 2'(enq) - 2'(deq);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/bsg_chip_host_link_selector.sv
// Routes the host fwd/rev link to one of num_channels_p attach points, draining
// outstanding traffic before any channel change.
module bsg_chip_host_link_selector
    import bsg_chip_host_link_selector_pkg::*;
#(
    parameter int unsigned num_channels_p  = host_link_num_channels_gp,
    parameter int unsigned fwd_width_p     = host_link_fwd_width_gp,
    parameter int unsigned rev_width_p     = host_link_rev_width_gp,
    parameter int unsigned max_out_p       = host_link_max_out_gp,
    parameter int unsigned drain_timeout_p = host_link_drain_timeout_gp,
    parameter int unsigned init_sel_p      = 0
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,

    input  logic                                        cfg_v_i,
    input  logic [$clog2(num_channels_p):0]             cfg_sel_i,
    output logic                                        cfg_ready_o,
    output logic [$clog2(num_channels_p)-1:0]           sel_o,
    output logic                                        busy_o,
    output logic [$clog2(max_out_p+1)-1:0]              outstanding_o,
    output logic                                        err_o,

    input  logic                                        host_fwd_v_i,
    input  logic [fwd_width_p-1:0]                      host_fwd_data_i,
    output logic                                        host_fwd_ready_o,

    output logic                                        host_rev_v_o,
    output logic [rev_width_p-1:0]                      host_rev_data_o,
    input  logic                                        host_rev_ready_i,

    output logic [num_channels_p-1:0]                   chan_fwd_v_o,
    output logic [num_channels_p-1:0][fwd_width_p-1:0]  chan_fwd_data_o,
    input  logic [num_channels_p-1:0]                   chan_fwd_ready_i,

    input  logic [num_channels_p-1:0]                   chan_rev_v_i,
    input  logic [num_channels_p-1:0][rev_width_p-1:0]  chan_rev_data_i,
    output logic [num_channels_p-1:0]                   chan_rev_ready_o
);

    localparam int unsigned sel_width_lp     = $clog2(num_channels_p);
    // One extra bit so out-of-range requests are representable and can be flagged.
    localparam int unsigned cfg_sel_width_lp = sel_width_lp + 1;
    localparam int unsigned out_width_lp     = $clog2(max_out_p + 1);
    localparam int unsigned timer_width_lp   = $clog2(drain_timeout_p + 1);

    host_link_state_e            state_q, state_d;
    logic [sel_width_lp-1:0]     sel_q, sel_d;
    logic [sel_width_lp-1:0]     next_sel_q, next_sel_d;
    logic [timer_width_lp-1:0]   timer_q, timer_d;
    logic                        err_q, err_d;

    logic                        cfg_err, drain_timeout;
    logic [num_channels_p-1:0]   sel_oh;
    logic                        stray_rev;

    logic                        fwd_fifo_ready, fwd_fifo_v, fwd_fifo_yumi, fwd_hs;
    logic [fwd_width_p-1:0]      fwd_fifo_data;
    logic                        rev_fifo_ready, rev_fifo_v, rev_hs;
    logic [rev_width_p-1:0]      rev_fifo_data;

    logic [out_width_lp-1:0]     count;
    logic                        count_full, count_underflow;

    assign sel_oh = num_channels_p'(1) << sel_q;

    // fwd path: host -> buffer -> selected channel
    assign host_fwd_ready_o = (state_q == ST_ACTIVE) & fwd_fifo_ready & ~count_full;
    assign fwd_hs           = host_fwd_v_i & host_fwd_ready_o;
    assign fwd_fifo_yumi    = fwd_fifo_v & chan_fwd_ready_i[sel_q];
    assign chan_fwd_v_o     = fwd_fifo_v ? sel_oh : '0;

    always_comb begin
        for (int i = 0; i < int'(num_channels_p); i++) begin
            chan_fwd_data_o[i] = fwd_fifo_data;
        end
    end

    bsg_two_fifo #(.width_p(fwd_width_p)) fwd_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (1'b0),
        .v_i       (host_fwd_v_i & host_fwd_ready_o),
        .data_i    (host_fwd_data_i),
        .ready_o   (fwd_fifo_ready),
        .v_o       (fwd_fifo_v),
        .data_o    (fwd_fifo_data),
        .yumi_i    (fwd_fifo_yumi)
    );

    // rev path: selected channel -> buffer -> host; other channels are always sunk
    assign chan_rev_ready_o = rev_fifo_ready ? '1 : ~sel_oh;
    assign stray_rev        = |(chan_rev_v_i & ~sel_oh);
    assign host_rev_v_o     = rev_fifo_v;
    assign host_rev_data_o  = rev_fifo_data;
    assign rev_hs           = rev_fifo_v & host_rev_ready_i;

    bsg_two_fifo #(.width_p(rev_width_p)) rev_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (drain_timeout),
        .v_i       (chan_rev_v_i[sel_q]),
        .data_i    (chan_rev_data_i[sel_q]),
        .ready_o   (rev_fifo_ready),
        .v_o       (rev_fifo_v),
        .data_o    (rev_fifo_data),
        .yumi_i    (rev_hs)
    );

    bsg_chip_host_link_credit_ctr #(.max_p(max_out_p)) credit_ctr (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .inc_i         (fwd_hs),
        .dec_i         (rev_hs),
        .clear_i       (drain_timeout),
        .count_o       (count),
        .full_o        (count_full),
        .underflow_c_o (count_underflow)
    );

    // Channel-select FSM
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        next_sel_d    = next_sel_q;
        timer_d       = timer_q;
        cfg_err       = 1'b0;
        drain_timeout = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                timer_d = '0;
                if (cfg_v_i) begin
                    if (cfg_sel_i >= cfg_sel_width_lp'(num_channels_p)) begin
                        cfg_err = 1'b1;
                    end else if (cfg_sel_i != cfg_sel_width_lp'(sel_q)) begin
                        next_sel_d = sel_width_lp'(cfg_sel_i);
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                timer_d = timer_q + timer_width_lp'(1);
                if ((count == '0) && !fwd_fifo_v && !rev_fifo_v) begin
                    state_d = ST_SWITCH;
                end else if (timer_q == timer_width_lp'(drain_timeout_p - 1)) begin
                    drain_timeout = 1'b1;
                    state_d       = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                sel_d   = next_sel_q;
                state_d = ST_ACTIVE;
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
        err_d = err_q | cfg_err | drain_timeout | stray_rev | count_underflow;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_ACTIVE;
            sel_q      <= sel_width_lp'(init_sel_p);
            next_sel_q <= sel_width_lp'(init_sel_p);
            timer_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            next_sel_q <= next_sel_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
        end
    end

    assign cfg_ready_o   = (state_q == ST_ACTIVE);
    assign busy_o        = (state_q != ST_ACTIVE);
    assign sel_o         = sel_q;
    assign outstanding_o = count;
    assign err_o         = err_q;

endmodule

// File: tb/tb_bsg_chip_host_link_selector.sv
// Self-checking bench for bsg_chip_host_link_selector: vector table plus scoreboarded streams.
module tb_bsg_chip_host_link_selector;

    localparam int unsigned N       = 4;
    localparam int unsigned FW      = 16;
    localparam int unsigned RW      = 8;
    localparam int unsigned MAX_OUT = 5;
    localparam int unsigned TMO     = 1024;
    localparam int unsigned SW      = $clog2(N);
    localparam int unsigned CSW     = SW + 1;
    localparam int unsigned OW      = $clog2(MAX_OUT + 1);

    logic                    clk;
    logic                    reset_n_i;
    logic                    cfg_v_i;
    logic [CSW-1:0]          cfg_sel_i;
    logic                    cfg_ready_o;
    logic [SW-1:0]           sel_o;
    logic                    busy_o;
    logic [OW-1:0]           outstanding_o;
    logic                    err_o;
    logic                    host_fwd_v_i;
    logic [FW-1:0]           host_fwd_data_i;
    logic                    host_fwd_ready_o;
    logic                    host_rev_v_o;
    logic [RW-1:0]           host_rev_data_o;
    logic                    host_rev_ready_i;
    logic [N-1:0]            chan_fwd_v_o;
    logic [N-1:0][FW-1:0]    chan_fwd_data_o;
    logic [N-1:0]            chan_fwd_ready_i;
    logic [N-1:0]            chan_rev_v_i;
    logic [N-1:0][RW-1:0]    chan_rev_data_i;
    logic [N-1:0]            chan_rev_ready_o;

    bsg_chip_host_link_selector #(
        .num_channels_p  (N),
        .fwd_width_p     (FW),
        .rev_width_p     (RW),
        .max_out_p       (MAX_OUT),
        .drain_timeout_p (TMO),
        .init_sel_p      (0)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n_i),
        .cfg_v_i          (cfg_v_i),
        .cfg_sel_i        (cfg_sel_i),
        .cfg_ready_o      (cfg_ready_o),
        .sel_o            (sel_o),
        .busy_o           (busy_o),
        .outstanding_o    (outstanding_o),
        .err_o            (err_o),
        .host_fwd_v_i     (host_fwd_v_i),
        .host_fwd_data_i  (host_fwd_data_i),
        .host_fwd_ready_o (host_fwd_ready_o),
        .host_rev_v_o     (host_rev_v_o),
        .host_rev_data_o  (host_rev_data_o),
        .host_rev_ready_i (host_rev_ready_i),
        .chan_fwd_v_o     (chan_fwd_v_o),
        .chan_fwd_data_o  (chan_fwd_data_o),
        .chan_fwd_ready_i (chan_fwd_ready_i),
        .chan_rev_v_i     (chan_rev_v_i),
        .chan_rev_data_i  (chan_rev_data_i),
        .chan_rev_ready_o (chan_rev_ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;
    int exp_sel = 0;
    int fwd_pulses [N];

    typedef struct { int ch; logic [FW-1:0] data; int cyc; } fwd_exp_t;
    typedef struct { logic [RW-1:0] data; int cyc; } rev_exp_t;
    fwd_exp_t fwd_q [$];
    rev_exp_t rev_q [$];

    typedef struct { logic [FW-1:0] fwd; logic [RW-1:0] rev; } vec_t;
    vec_t tbl [5];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input string name);
        nvec++;
        nfail++;
        $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 30000) begin
            $display("FAIL watchdog: bench exceeded cycle budget");
            $fatal(1, "bench timeout");
        end
    end

    // Scoreboard: expectations are queued at the host/channel handshake and popped at delivery
    always @(negedge clk) begin
        fwd_exp_t fe;
        rev_exp_t re;
        if (host_fwd_v_i && host_fwd_ready_o)
            fwd_q.push_back('{exp_sel, host_fwd_data_i, cyc});
        for (int i = 0; i < int'(N); i++) begin
            if (chan_fwd_v_o[i] && chan_fwd_ready_i[i]) begin
                fwd_pulses[i]++;
                if (fwd_q.size() == 0) begin
                    fail_now("fwd_unexpected");
                end else begin
                    fe = fwd_q.pop_front();
                    check("fwd_channel", 64'(i), 64'(fe.ch));
                    check("fwd_data", 64'(chan_fwd_data_o[i]), 64'(fe.data));
                    check("fwd_latency", 64'(cyc - fe.cyc), 64'd1);
                end
            end
        end
        if (chan_rev_v_i[exp_sel] && chan_rev_ready_o[exp_sel])
            rev_q.push_back('{chan_rev_data_i[exp_sel], cyc});
        if (host_rev_v_o && host_rev_ready_i) begin
            if (rev_q.size() == 0) begin
                fail_now("rev_unexpected");
            end else begin
                re = rev_q.pop_front();
                check("rev_data", 64'(host_rev_data_o), 64'(re.data));
                check("rev_latency", 64'(cyc - re.cyc), 64'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_fwd(input logic [FW-1:0] d);
        int n = 0;
        host_fwd_v_i    = 1'b1;
        host_fwd_data_i = d;
        @(negedge clk);
        while (!host_fwd_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("fwd_accept_timeout");
        tick();
        host_fwd_v_i = 1'b0;
    endtask

    task automatic send_rev(input int ch, input logic [RW-1:0] d);
        int n = 0;
        chan_rev_v_i[ch]    = 1'b1;
        chan_rev_data_i[ch] = d;
        @(negedge clk);
        while (!chan_rev_ready_o[ch] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("rev_accept_timeout");
        tick();
        chan_rev_v_i[ch] = 1'b0;
    endtask

    task automatic do_cfg(input logic [CSW-1:0] s);
        cfg_v_i   = 1'b1;
        cfg_sel_i = s;
        tick();
        cfg_v_i   = 1'b0;
    endtask

    initial begin
        int p0;
        reset_n_i        = 1'b0;
        cfg_v_i          = 1'b0;
        cfg_sel_i        = '0;
        host_fwd_v_i     = 1'b0;
        host_fwd_data_i  = '0;
        host_rev_ready_i = 1'b1;
        chan_fwd_ready_i = '1;
        chan_rev_v_i     = '0;
        chan_rev_data_i  = '0;
        for (int i = 0; i < int'(N); i++) fwd_pulses[i] = 0;
        tbl[0] = '{16'h1111, 8'hA1};
        tbl[1] = '{16'h2345, 8'hB2};
        tbl[2] = '{16'hBEEF, 8'hC3};
        tbl[3] = '{16'h0F0F, 8'hD4};
        tbl[4] = '{16'hFFFF, 8'h5A};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel", 64'(sel_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_out", 64'(outstanding_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_chan_fwd_v", 64'(chan_fwd_v_o), 64'd0);
        check("rst_host_rev_v", 64'(host_rev_v_o), 64'd0);
        check("rst_fwd_ready", 64'(host_fwd_ready_o), 64'd1);
        check("rst_cfg_ready", 64'(cfg_ready_o), 64'd1);
        check("rst_chan_rev_ready", 64'(chan_rev_ready_o), 64'hF);
        reset_n_i = 1'b1;
        tick();

        // 1: table-driven requests and responses on channel 0
        p0 = fwd_pulses[0];
        for (int i = 0; i < 5; i++) begin
            send_fwd(tbl[i].fwd);
            check("t1_out_up", 64'(outstanding_o), 64'(i + 1));
        end
        tick();
        check("t1_ch0_pulses", 64'(fwd_pulses[0] - p0), 64'd5);
        for (int i = 0; i < 5; i++) begin
            send_rev(0, tbl[i].rev);
            tick();
            check("t1_out_down", 64'(outstanding_o), 64'(4 - i));
        end
        check("t1_err", 64'(err_o), 64'd0);

        // 2: drain three outstanding, then switch to channel 2
        for (int i = 0; i < 3; i++) send_fwd(FW'(16'h4000 + i));
        do_cfg(3'd2);
        check("t2_busy", 64'(busy_o), 64'd1);
        check("t2_fwd_blocked", 64'(host_fwd_ready_o), 64'd0);
        check("t2_cfg_ready", 64'(cfg_ready_o), 64'd0);
        for (int i = 0; i < 3; i++) send_rev(0, RW'(8'h50 + i));
        tick();
        check("t2_out_zero", 64'(outstanding_o), 64'd0);
        check("t2_still_drain", 64'(busy_o), 64'd1);
        tick();
        check("t2_switch_busy", 64'(busy_o), 64'd1);
        check("t2_switch_sel_old", 64'(sel_o), 64'd0);
        tick();
        check("t2_sel_new", 64'(sel_o), 64'd2);
        check("t2_active", 64'(busy_o), 64'd0);
        exp_sel = 2;
        send_fwd(16'h2222);
        check("t2_out_one", 64'(outstanding_o), 64'd1);

        // 3: credit limit on channel 2
        for (int i = 0; i < 4; i++) send_fwd(FW'(16'h3000 + i));
        check("t3_out_max", 64'(outstanding_o), 64'(MAX_OUT));
        host_fwd_v_i    = 1'b1;
        host_fwd_data_i = 16'h3333;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_fwd_blocked", 64'(host_fwd_ready_o), 64'd0);
        end
        send_rev(2, 8'h60);
        tick();
        check("t3_out_after_rsp", 64'(outstanding_o), 64'(MAX_OUT - 1));
        check("t3_fwd_ready_again", 64'(host_fwd_ready_o), 64'd1);
        tick();
        host_fwd_v_i = 1'b0;
        check("t3_out_refilled", 64'(outstanding_o), 64'(MAX_OUT));
        check("t3_fwd_blocked_again", 64'(host_fwd_ready_o), 64'd0);
        for (int i = 0; i < 3; i++) send_rev(2, RW'(8'h70 + i));
        tick();
        check("t3_out_two", 64'(outstanding_o), 64'd2);

        // 4: drain timeout with two requests never answered
        do_cfg(3'd1);
        check("t4_busy", 64'(busy_o), 64'd1);
        repeat (TMO - 1) tick();
        check("t4_pre_busy", 64'(busy_o), 64'd1);
        check("t4_pre_err", 64'(err_o), 64'd0);
        check("t4_pre_out", 64'(outstanding_o), 64'd2);
        tick();
        check("t4_err", 64'(err_o), 64'd1);
        check("t4_out_cleared", 64'(outstanding_o), 64'd0);
        check("t4_switch_sel_old", 64'(sel_o), 64'd2);
        tick();
        check("t4_sel_new", 64'(sel_o), 64'd1);
        check("t4_active", 64'(busy_o), 64'd0);
        exp_sel = 1;

        // 6: reset while draining with flits stuck in the fwd buffer
        chan_fwd_ready_i[1] = 1'b0;
        send_fwd(16'h6001);
        send_fwd(16'h6002);
        do_cfg(3'd3);
        repeat (4) tick();
        check("t6_draining", 64'(busy_o), 64'd1);
        check("t6_fwd_stuck", 64'(chan_fwd_v_o), 64'h2);
        reset_n_i = 1'b0;
        #1;
        check("t6_sel", 64'(sel_o), 64'd0);
        check("t6_busy", 64'(busy_o), 64'd0);
        check("t6_out", 64'(outstanding_o), 64'd0);
        check("t6_chan_fwd_v", 64'(chan_fwd_v_o), 64'd0);
        check("t6_err", 64'(err_o), 64'd0);
        fwd_q.delete();
        rev_q.delete();
        exp_sel = 0;
        chan_fwd_ready_i = '1;
        tick();
        reset_n_i = 1'b1;
        tick();

        // 5a: response on an unselected channel is dropped and flagged
        check("t5_err_clean", 64'(err_o), 64'd0);
        check("t5_unsel_ready", 64'(chan_rev_ready_o[1]), 64'd1);
        chan_rev_v_i[1]    = 1'b1;
        chan_rev_data_i[1] = 8'hEE;
        tick();
        chan_rev_v_i[1] = 1'b0;
        check("t5_stray_err", 64'(err_o), 64'd1);
        check("t5_stray_dropped", 64'(host_rev_v_o), 64'd0);
        tick();
        check("t5_stray_dropped2", 64'(host_rev_v_o), 64'd0);

        // 5b: same-channel request is a no-op; out-of-range request is flagged
        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        tick();
        do_cfg(3'd0);
        check("t5_same_busy", 64'(busy_o), 64'd0);
        check("t5_same_err", 64'(err_o), 64'd0);
        do_cfg(3'd7);
        check("t5_oor_err", 64'(err_o), 64'd1);
        check("t5_oor_busy", 64'(busy_o), 64'd0);
        check("t5_oor_sel", 64'(sel_o), 64'd0);
        check("t5_oor_cfg_ready", 64'(cfg_ready_o), 64'd1);

        repeat (4) tick();
        check("end_fwd_q_empty", 64'(fwd_q.size()), 64'd0);
        check("end_rev_q_empty", 64'(rev_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
